// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative multiplier (and the divider).
package mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int unsigned MULT_W = 32;
  localparam int unsigned CNT_W  = $clog2(MULT_W);
  localparam int unsigned ABS_W  = 64;

  // Two's-complement magnitude; callers zero-extend and truncate back to their width.
  function automatic logic [ABS_W-1:0] abs_w(input logic [ABS_W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/mult_seq_dp.sv
// Datapath of mult_seq: operand magnitudes, shift-add accumulator and final sign fix.
// MULT_SEQ_EARLY_TERM_EN: exposes an "all remaining multiplier bits are zero" flag.
module mult_seq_dp
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_W,
  parameter int unsigned CW    = CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [CW-1:0]      cnt,
  output logic               early_c,
  output logic [2*WIDTH-1:0] z
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             neg;
  logic [PW-1:0]    acc;

`ifdef MULT_SEQ_EARLY_TERM_EN
  assign early_c = (mplier == '0);
`else
  assign early_c = 1'b0;
`endif

  // Magnitudes are latched so -2^(W-1) becomes 2^(W-1), still representable unsigned.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      z      <= '0;
    end else if (load) begin
      mcand  <= WIDTH'(abs_w(ABS_W'(a), is_signed & a[WIDTH-1]));
      mplier <= WIDTH'(abs_w(ABS_W'(b), is_signed & b[WIDTH-1]));
      neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc    <= '0;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + (PW'(mcand) << cnt);
      end
      mplier <= mplier >> 1;
    end else if (finish) begin
      z <= neg ? -acc : acc;
    end
  end

endmodule

// File: rtl/mult_seq.sv
// Iterative shift-add multiplier with start/busy/done handshake and signed/unsigned mode.
// MULT_SEQ_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module mult_seq
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] z
);

  localparam int unsigned CW = (WIDTH == MULT_W) ? CNT_W : $clog2(WIDTH);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          fin;
  logic          accept_c;
  logic          finish_c;
  logic          step_c;
  logic          early_c;

  // The first RUN cycle always steps, so b=0 still takes two edges under early termination.
  assign accept_c = start && (state != RUN);
  assign finish_c = (state == RUN) && (fin || (early_c && (cnt != '0)));
  assign step_c   = (state == RUN) && !finish_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      fin   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            cnt   <= '0;
            fin   <= 1'b0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (finish_c) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
            fin <= (cnt == CW'(WIDTH - 1));
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  mult_seq_dp #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_dp (
    .clk       (clk),
    .reset     (reset),
    .load      (accept_c),
    .step      (step_c),
    .finish    (finish_c),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .cnt       (cnt),
    .early_c   (early_c),
    .z         (z)
  );

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq (WIDTH=32); adapts expected latency to MULT_SEQ_EARLY_TERM_EN.
module tb_mult_seq;

`ifdef MULT_SEQ_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [63:0] z;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] z;
    int          start_edge;
    int          lat;
  } exp_t;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] z;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  logic [63:0] mz = '0;

  mult_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .z         (z)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h (edge %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    if (sgn) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
    end else begin
      sx = {32'b0, x};
      sy = {32'b0, y};
    end
    return 64'(sx * sy);
  endfunction

  function automatic int exp_lat(input logic sgn, input logic [31:0] y);
    logic [31:0] m;
    int          h;
    m = (sgn && y[31]) ? -y : y;
    h = -1;
    for (int i = 0; i < 32; i++) if (m[i]) h = i;
    return EARLY ? ((h < 0) ? 2 : h + 2) : 33;
  endfunction

  // Monitor: pops the scoreboard on done and tracks the value z must hold otherwise.
  always begin
    logic r;
    exp_t e;
    @(posedge clk);
    r = reset;
    #1;
    if (r) begin
      mz = '0;
      check("reset_done", 64'(done), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
    end else if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
        mz = z;
      end else begin
        e = sb.pop_front();
        check("z", z, e.z);
        check("latency", 64'(cyc - e.start_edge), 64'(e.lat));
        check("busy_at_done", 64'(busy), 64'd0);
        mz = e.z;
      end
    end
    if (!done) check("z_hold", z, mz);
  end

  // Caller is at a negedge; start is sampled on the following posedge.
  task automatic start_op(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] expz);
    start     = 1'b1;
    is_signed = sgn;
    a         = x;
    b         = y;
    sb.push_back('{z: expz, start_edge: cyc + 1, lat: exp_lat(sgn, y)});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic wait_done_level();
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    vecs.push_back('{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 64'h0});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 64'h0});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001});
    vecs.push_back('{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001});
    vecs.push_back('{1'b1, 32'h8000_0080, 32'h0000_00AA, 64'hFFFF_FFAB_0000_5500});
    vecs.push_back('{1'b1, 32'h0000_00AA, 32'h8000_0080, 64'hFFFF_FFAB_0000_5500});
    vecs.push_back('{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000});
    vecs.push_back('{1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 64'h0});
    vecs.push_back('{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 64'h0});
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(1));
      vecs.push_back('{rs, ra, rb, ref_mul(rs, ra, rb)});
    end

    // Reset state while reset is still held.
    #100;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_z", z, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      start_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].z);
      drain();
    end

    // Back-to-back: second start issued during the done cycle.
    start_op(1'b0, 32'hED, 32'hD0, 64'hC090);
    wait_done_level();
    start_op(1'b0, 32'h8F, 32'h0E, 64'h7D2);
    drain();

    // Start during RUN is ignored and must not disturb the running product.
    start_op(1'b0, 32'h1234_5678, 32'h8765_4321, ref_mul(1'b0, 32'h1234_5678, 32'h8765_4321));
    repeat (4) @(negedge clk);
    start = 1'b1;
    is_signed = 1'b1;
    a = 32'hDEAD_BEEF;
    b = 32'h0BAD_F00D;
    @(negedge clk);
    start = 1'b0;
    check("busy_run", 64'(busy), 64'd1);
    drain();
    repeat (40) @(negedge clk);

    // Reset mid-RUN abandons the operation without a done.
    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    sb.delete(sb.size() - 1);
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_z", z, 64'd0);

    // Reset and start together: reset wins.
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("rst_start_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("rst_start_idle", 64'(busy), 64'd0);

    start_op(1'b0, 32'h7, 32'h3, 64'h15);
    drain();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
